// File: rtl/memram_sdp.sv
// Simple-dual-port RAM with a registered read port and a hardware clear sweep.
// Contents are never reset; the sweep fills them with INIT_VAL after reset or on clr.
module memram_sdp #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 5,
    parameter logic [DATA_W-1:0] INIT_VAL = '0,
    parameter int                RDW_MODE = 0,
    parameter int                CLEAR_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] din,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] dout,
    output logic              rvalid,
    input  logic              clr,
    output logic              busy
);
    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= (CLEAR_EN != 0) ? S_CLEAR : S_READY;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        mem_we    = 1'b0;
        mem_wa    = waddr;
        mem_wd    = din;
        rd_en     = 1'b0;
        case (state)
            S_CLEAR: begin
                mem_we = 1'b1;
                mem_wa = ptr;
                mem_wd = INIT_VAL;
                if (clr) begin
                    ptr_nxt = '0;
                end else if (ptr == PTR_LAST) begin
                    state_nxt = S_READY;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + ADDR_W'(1);
                end
            end
            default: begin
                if (clr) begin
                    // Accesses in the clr cycle are dropped, not deferred.
                    state_nxt = S_CLEAR;
                    ptr_nxt   = '0;
                end else begin
                    mem_we = we;
                    rd_en  = re;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    // Same-address read-during-write: bypass din, or let the array return old data.
    generate
        if (RDW_MODE == 1) begin : g_rdw_new
            assign rd_data = (mem_we && mem_wa == raddr) ? mem_wd : mem[raddr];
        end else begin : g_rdw_old
            assign rd_data = mem[raddr];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout   <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_en;
            if (rd_en) dout <= rd_data;
        end
    end

    assign busy = (state == S_CLEAR);

endmodule

// File: doc/memram_sdp.md
Name: memram_sdp

Overview:
- Parametrised simple-dual-port RAM: one write port and one registered read port.
- Successor to the 8x32 asynchronous-read scratch RAM used by the Natalius core.
- Adds:
  - configurable width and depth;
  - independent read and write addresses;
  - registered read with a valid strobe;
  - selectable read-during-write behaviour;
  - a hardware clear sequencer that fills the array with INIT_VAL after reset or on request.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W words.
- INIT_VAL, 0, word written to every location by the clear sweep (DATA_W bits).
- RDW_MODE, 0, read-during-write to the same address: 0 = return old data, 1 = return new (written) data.
- CLEAR_EN, 1, 1 = run the clear sweep after reset; 0 = leave reset in READY with contents undefined (clr still works).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- din  in  DATA_W  write data
- re  in  1  read enable
- raddr  in  ADDR_W  read address
- dout  out  DATA_W  registered read data
- rvalid  out  1  dout updated this cycle
- clr  in  1  start or restart the clear sweep (single-cycle pulse or level)
- busy  out  1  clear sweep in progress; all accesses ignored

Behaviour:
- Reset (async, rst=1): dout=0, rvalid=0, ptr=0.
  - State is CLEAR when CLEAR_EN=1 (busy=1); READY when CLEAR_EN=0 (busy=0).
  - Array contents are not reset.
- FSM has two states, CLEAR and READY.
- CLEAR:
  - Each cycle writes INIT_VAL to mem[ptr], then ptr<=ptr+1.
  - The cycle that writes ptr==DEPTH-1 transitions to READY and sets ptr<=0.
  - The sweep occupies exactly DEPTH cycles; busy=1 for all of them and falls on the next edge.
  - clr=1 in CLEAR restarts the sweep: ptr<=0, and mem[0] is written again on the next cycle.
- READY:
  - clr=1: go to CLEAR, ptr<=0, busy=1 from the next cycle. we and re in that cycle are dropped and rvalid<=0.
  - Otherwise, we=1 writes din to mem[waddr] at the edge.
  - Otherwise, re=1 loads dout<=mem[raddr] at the edge and sets rvalid<=1, giving 1-cycle latency.
  - re=0: rvalid<=0 and dout holds its last value.
- While busy=1: we and re are ignored, rvalid=0, dout holds.
- Read-during-write (we=re=1, waddr==raddr, READY):
  - RDW_MODE=0: dout gets the pre-write contents.
  - RDW_MODE=1: dout gets din.
  - Different addresses: both operations complete in the same cycle, independently.
- Address arithmetic:
  - ptr is ADDR_W bits, and the sweep termination compares to DEPTH-1.
  - No out-of-range addresses exist.
- Reset asserted mid-sweep or mid-access: outputs return to reset values immediately. With CLEAR_EN=1 the sweep restarts from 0 after deassertion. Partially cleared contents are then fully overwritten.
- Back-to-back reads on consecutive cycles give continuous rvalid=1 with one new word per cycle.
- Target: infers block/distributed RAM with a synchronous read port; no combinational path from raddr to dout.

Test Plan:
- Reset, defaults: after rst falls, busy=1 for exactly 32 cycles and then 0. Reading addresses 0..31 then gives dout=0x00 each, rvalid=1, one cycle after each re.
- Write then read: we at waddr=5 with din=0xA5; next cycle re at raddr=5. The following cycle shows dout=0xA5, rvalid=1. The cycle after, with re=0, shows rvalid=0 and dout stays 0xA5.
- RDW, RDW_MODE=0: mem[3]=0x11, then we=re=1 at address 3 with din=0x22. Expect dout=0x11, and a subsequent read of 3 returns 0x22. Repeat with RDW_MODE=1: expect dout=0x22 immediately.
- Clear with INIT_VAL=0x5A:
  - Fill all addresses with their index, then pulse clr together with we at waddr=7, din=0xFF.
  - Expect the write dropped and busy=1 for 32 cycles.
  - Pulse clr again at sweep cycle 10; busy is then extended to 10+32 cycles total.
  - Afterwards every address reads 0x5A.
- Access during busy: issue re and we every cycle of the sweep. Expect rvalid=0 throughout and contents equal to INIT_VAL afterwards.
- Mid-sweep reset, DATA_W=16, ADDR_W=4: assert rst at sweep cycle 7. Expect dout=0x0000, rvalid=0, busy=1 after release, and a 16-cycle full sweep. Also a stream of 16 consecutive reads gives rvalid high for 16 consecutive cycles.
